// File: rtl/vend_arbiter.sv
// Round-robin scheduler that time-shares one vending machine core among N panels.
// Grants a panel, clears the core, feeds choice then money, and returns the result.
module vend_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [2*N-1:0] req_choice,
    input  logic [4*N-1:0] req_money,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           ok,
    output logic [3:0]     change_out,
    output logic           busy,
    output logic           vm_reset,
    output logic [1:0]     vm_choice,
    output logic [3:0]     vm_money,
    input  logic           vm_delivery,
    input  logic [3:0]     vm_change
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, SELECT, PAY, DONE} state_t;

    state_t        state;
    logic [IW-1:0] rr, gidx, sel;
    logic          found;
    logic [TW-1:0] timer;
    logic [1:0]    lat_choice;
    logic [3:0]    lat_money;
    logic [1:0]    sel_choice;
    logic [3:0]    sel_money;

    // First requesting panel at or after the pointer, wrapping around.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(rr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
        sel_choice = req_choice[2*int'(sel) +: 2];
        sel_money  = req_money[4*int'(sel) +: 4];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            done       <= '0;
            ok         <= 1'b0;
            change_out <= '0;
            busy       <= 1'b0;
            vm_reset   <= 1'b1;
            vm_choice  <= '0;
            vm_money   <= '0;
            rr         <= '0;
            gidx       <= '0;
            timer      <= '0;
            lat_choice <= '0;
            lat_money  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vm_reset  <= 1'b0;
                    vm_choice <= '0;
                    vm_money  <= '0;
                    if (found) begin
                        gnt        <= '0;
                        gnt[sel]   <= 1'b1;
                        gidx       <= sel;
                        lat_choice <= sel_choice;
                        lat_money  <= sel_money;
                        busy       <= 1'b1;
                        if (sel_choice != 2'b00) begin
                            state    <= CLEAR;
                            vm_reset <= 1'b1;
                        end else begin
                            // Invalid product: refund without touching the core.
                            state      <= DONE;
                            done[sel]  <= 1'b1;
                            ok         <= 1'b0;
                            change_out <= sel_money;
                        end
                    end
                end
                CLEAR: begin
                    state     <= SELECT;
                    vm_reset  <= 1'b0;
                    vm_choice <= lat_choice;
                    vm_money  <= '0;
                end
                SELECT: begin
                    state    <= PAY;
                    vm_money <= lat_money;
                    timer    <= '0;
                end
                PAY: begin
                    timer <= timer + 1'b1;
                    if (vm_delivery || timer == TW'(TIMEOUT - 1)) begin
                        state      <= DONE;
                        done[gidx] <= 1'b1;
                        vm_choice  <= '0;
                        vm_money   <= '0;
                        // Delivery on the final cycle still counts as a sale.
                        ok         <= vm_delivery;
                        change_out <= vm_delivery ? vm_change : lat_money;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    timer <= '0;
                    rr    <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vend_arbiter.sv
// Directed bench for vend_arbiter: grant order, core sequencing, timeout refund,
// invalid choice, reset abort and input latching.
module tb_vend_arbiter;
    localparam int N = 4;
    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [7:0]   req_choice = '0;
    logic [15:0]  req_money = '0;
    logic [N-1:0] gnt, done;
    logic         ok, busy, vm_reset;
    logic [3:0]   change_out, vm_money;
    logic [1:0]   vm_choice;
    logic         vm_delivery = 1'b0;
    logic [3:0]   vm_change = '0;

    int checks = 0;
    int errors = 0;

    vend_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_choice(req_choice),
        .req_money(req_money), .gnt(gnt), .done(done), .ok(ok),
        .change_out(change_out), .busy(busy), .vm_reset(vm_reset),
        .vm_choice(vm_choice), .vm_money(vm_money),
        .vm_delivery(vm_delivery), .vm_change(vm_change)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        vm_delivery = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({gnt, done, ok, change_out, busy, vm_reset, vm_choice, vm_money} !==
            {4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b1, 2'b0, 4'b0}) begin
            errors++;
            $display("FAIL reset: gnt=%b done=%b ok=%b chg=%h busy=%b vmr=%b vmc=%b vmm=%h",
                     gnt, done, ok, change_out, busy, vm_reset, vm_choice, vm_money);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (vm_reset !== 1'b0) begin
            errors++; $display("FAIL idle_vm_reset: got %b want 0", vm_reset);
        end
    endtask

    task automatic test_delivery();
        req = 4'b0001; req_choice[1:0] = 2'b10; req_money[3:0] = 4'b1010;
        tick();
        checks++;
        if ({gnt, vm_reset, busy} !== {4'b0001, 1'b1, 1'b1}) begin
            errors++; $display("FAIL clear: gnt=%b vmr=%b busy=%b want 0001 1 1", gnt, vm_reset, busy);
        end
        tick();
        checks++;
        if ({vm_reset, vm_choice, vm_money} !== {1'b0, 2'b10, 4'b0}) begin
            errors++; $display("FAIL select: vmr=%b vmc=%b vmm=%h want 0 10 0", vm_reset, vm_choice, vm_money);
        end
        tick();
        checks++;
        if (vm_money !== 4'b1010) begin
            errors++; $display("FAIL pay_money: got %b want 1010", vm_money);
        end
        vm_delivery = 1'b1; vm_change = 4'b0101;
        tick();
        vm_delivery = 1'b0; req = '0;
        checks++;
        if ({done, ok, change_out} !== {4'b0001, 1'b1, 4'b0101}) begin
            errors++; $display("FAIL deliver_done: done=%b ok=%b chg=%b want 0001 1 0101", done, ok, change_out);
        end
        tick();
        checks++;
        if ({gnt, done, ok, change_out, busy} !== {4'b0, 4'b0, 1'b1, 4'b0101, 1'b0}) begin
            errors++; $display("FAIL after_done: gnt=%b done=%b ok=%b chg=%b busy=%b", gnt, done, ok, change_out, busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_choice = 8'b00_00_00_00;
        req_money = 16'h9043;
        req = 4'b0011;
        tick();
        checks++;
        if ({gnt, done, change_out} !== {4'b0001, 4'b0001, 4'h3}) begin
            errors++; $display("FAIL rr_first: gnt=%b done=%b chg=%h want 0001 0001 3", gnt, done, change_out);
        end
        tick();
        tick();
        checks++;
        if ({gnt, change_out} !== {4'b0010, 4'h4}) begin
            errors++; $display("FAIL rr_second: gnt=%b chg=%h want 0010 4", gnt, change_out);
        end
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL rr_wrap: gnt=%b want 0001", gnt);
        end
        tick();
        req = 4'b1001;
        tick();
        checks++;
        if ({gnt, change_out} !== {4'b1000, 4'h9}) begin
            errors++; $display("FAIL rr_ptr1: gnt=%b chg=%h want 1000 9", gnt, change_out);
        end
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        bit early = 0;
        req = 4'b0100; req_choice[5:4] = 2'b10; req_money[11:8] = 4'b0001;
        tick(); tick(); tick();
        req = '0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            if (done !== 4'b0) early = 1;
        end
        checks++;
        if (early) begin
            errors++; $display("FAIL timeout_early: done seen before %0d PAY cycles", TIMEOUT);
        end
        tick();
        checks++;
        if ({done, ok, change_out} !== {4'b0100, 1'b0, 4'b0001}) begin
            errors++; $display("FAIL timeout_done: done=%b ok=%b chg=%b want 0100 0 0001", done, ok, change_out);
        end
        tick();
    endtask

    task automatic test_invalid_choice();
        bit core_touched = 0;
        int n = 0;
        req = 4'b0010; req_choice[3:2] = 2'b00; req_money[7:4] = 4'b0111;
        while (done === 4'b0 && n < 3) begin
            tick();
            n++;
            if ({vm_reset, vm_choice, vm_money} !== 7'b0) core_touched = 1;
        end
        req = '0;
        checks++;
        if (n > 2 || {done, ok, change_out} !== {4'b0010, 1'b0, 4'b0111}) begin
            errors++; $display("FAIL invalid_done: cycles=%0d done=%b ok=%b chg=%b want <=2 0010 0 0111",
                               n, done, ok, change_out);
        end
        tick();
        if ({vm_reset, vm_choice, vm_money} !== 7'b0) core_touched = 1;
        checks++;
        if (core_touched) begin
            errors++; $display("FAIL invalid_core: core inputs driven, want all 0");
        end
    endtask

    task automatic test_reset_mid_pay();
        bit saw_done = 0;
        req = 4'b0100; req_choice[5:4] = 2'b01; req_money[11:8] = 4'h5;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt, busy, vm_reset, vm_money, done} !== {4'b0, 1'b0, 1'b1, 4'b0, 4'b0}) begin
            errors++; $display("FAIL reset_abort: gnt=%b busy=%b vmr=%b vmm=%h done=%b",
                               gnt, busy, vm_reset, vm_money, done);
        end
        req = '0;
        tick();
        if (done !== 4'b0) saw_done = 1;
        reset = 1'b0;
        tick();
        if (done !== 4'b0) saw_done = 1;
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL reset_no_done: done pulsed after abort");
        end
        req_choice[1:0] = 2'b00; req_choice[5:4] = 2'b00;
        req = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL reset_ptr: gnt=%b want 0001", gnt);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_latching();
        req = 4'b0001; req_choice[1:0] = 2'b01; req_money[3:0] = 4'b1100;
        tick(); tick(); tick();
        req = '0; req_money[3:0] = 4'b0011; req_choice[1:0] = 2'b11;
        tick(); tick();
        checks++;
        if ({vm_choice, vm_money} !== {2'b01, 4'b1100}) begin
            errors++; $display("FAIL latch_pay: vmc=%b vmm=%b want 01 1100", vm_choice, vm_money);
        end
        vm_delivery = 1'b1; vm_change = 4'b0010;
        tick();
        vm_delivery = 1'b0;
        checks++;
        if ({done, ok, change_out} !== {4'b0001, 1'b1, 4'b0010}) begin
            errors++; $display("FAIL latch_done: done=%b ok=%b chg=%b want 0001 1 0010", done, ok, change_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_delivery();
        test_round_robin();
        test_timeout();
        test_invalid_choice();
        test_reset_mid_pay();
        test_latching();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
